// File: rtl/instr_fetch.sv
// instr_fetch: PC owner, single-outstanding imem fetcher and instruction FIFO
// Ports: clk/reset (sync, active-high); redirect/redirect_pc flush and refetch;
// imem_req/imem_addr/imem_ack/imem_rdata memory handshake; instr_valid/
// instr_ready/instruction/PC datapath handshake; fetch_fault misaligned target.
// Option: define IFETCH_ALIGN_CHK_EN for a sticky fault on misaligned redirects;
// otherwise redirect_pc[1:0] is forced to zero and fetch_fault is tied low.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruction,
  output logic [31:0] PC,
  output logic        fetch_fault
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;
  state_t state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d, drain_addr_q, drain_addr_d, rpc;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [31:0] data_q [DEPTH];
  logic [31:0] addr_q [DEPTH];
  logic fault_q, pop, push;
`ifdef IFETCH_ALIGN_CHK_EN
  assign rpc = redirect_pc;
  always_ff @(posedge clk)
    if (reset) fault_q <= 1'b0;
    else if (redirect) fault_q <= |redirect_pc[1:0];
`else
  assign rpc = redirect_pc & ~32'h3;
  assign fault_q = 1'b0;
`endif
  assign fetch_fault = !reset && fault_q;
  assign instr_valid = !reset && count_q != '0;
  assign instruction = instr_valid ? data_q[rd_ptr_q] : 32'h0;
  assign PC = instr_valid ? addr_q[rd_ptr_q] : 32'h0;
  assign pop = instr_valid && instr_ready;
  // A pop frees a slot this cycle, so a full FIFO may issue alongside it.
  assign imem_req = !reset && (state_q != IDLE || (!fault_q && (count_q != FULL || pop)));
  // DRAIN replays the address captured before the redirect moved fetch_pc.
  assign imem_addr = state_q == DRAIN ? drain_addr_q : fetch_pc_q;
  assign push = imem_req && imem_ack && !redirect && state_q != DRAIN;
  always_comb begin
    state_d = (!imem_req || imem_ack) ? IDLE : (redirect || state_q == DRAIN) ? DRAIN : WAIT;
    fetch_pc_d = redirect ? rpc : push ? fetch_pc_q + 32'd4 : fetch_pc_q;
    drain_addr_d = state_q == DRAIN ? drain_addr_q : fetch_pc_q;
    count_d = redirect ? '0 : count_q + CW'(push) - CW'(pop);
    wr_ptr_d = redirect ? '0 : wr_ptr_q + AW'(push);
    rd_ptr_d = redirect ? '0 : rd_ptr_q + AW'(pop);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      fetch_pc_q <= RESET_PC;
      drain_addr_q <= RESET_PC;
      count_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      fetch_pc_q <= fetch_pc_d;
      drain_addr_q <= drain_addr_d;
      count_q <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
  always_ff @(posedge clk)
    if (push) begin
      data_q[wr_ptr_q] <= imem_rdata;
      addr_q[wr_ptr_q] <= imem_addr;
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed self-checking bench for instr_fetch
module tb_instr_fetch;
  logic clk = 1'b0, reset = 1'b1, redirect = 1'b0, instr_ready = 1'b1;
  logic [31:0] redirect_pc = 32'h0;
  logic imem_req, imem_ack, instr_valid, fetch_fault;
  logic [31:0] imem_addr, imem_rdata, instruction, PC;
  int lat = 0, wait_cnt = 0, n_run = 0, n_fail = 0;
  bit found;
  instr_fetch dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instruction(instruction), .PC(PC), .fetch_fault(fetch_fault)
  );
  always #5 clk = ~clk;
  assign imem_ack = imem_req && wait_cnt >= lat;
  assign imem_rdata = imem_addr + 32'h1000_0000;
  always @(posedge clk) wait_cnt <= (reset || !imem_req || imem_ack) ? 0 : wait_cnt + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input logic rdy, input logic rd, input logic [31:0] rpc);
    @(negedge clk);
    reset = 1'b0;
    instr_ready = rdy;
    redirect = rd;
    redirect_pc = rpc;
    #1;
  endtask
  task automatic do_reset(input int l);
    @(negedge clk);
    reset = 1'b1;
    redirect = 1'b0;
    instr_ready = 1'b1;
    lat = l;
    repeat (2) @(negedge clk);
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    do_reset(0);
    check("rst_req", imem_req, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instruction, 0);
    check("rst_pc", PC, 0);
    check("rst_fault", fetch_fault, 0);
    step(1, 0, 0);
    check("zw_req0", imem_req, 1);
    check("zw_addr0", imem_addr, 0);
    check("zw_nv0", instr_valid, 0);
    for (int i = 1; i <= 3; i++) begin
      step(1, 0, 0);
      check("zw_valid", instr_valid, 1);
      check("zw_pc", PC, 32'(4 * (i - 1)));
      check("zw_instr", instruction, 32'h1000_0000 + 32'(4 * (i - 1)));
      check("zw_addr", imem_addr, 32'(4 * i));
    end
    step(0, 0, 0);
    check("bp_req_c4", imem_req, 1);
    check("bp_pc_c4", PC, 32'd12);
    step(0, 0, 0);
    check("bp_full_req", imem_req, 0);
    check("bp_full_pc", PC, 32'd12);
    step(1, 0, 0);
    check("bp_resume_req", imem_req, 1);
    check("bp_resume_addr", imem_addr, 32'd20);
    check("bp_pop_pc", PC, 32'd12);
    step(1, 0, 0);
    check("bp_order1", PC, 32'd16);
    step(1, 0, 0);
    check("bp_order2", PC, 32'd20);
    do_reset(3);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0);
      check("w3_req", imem_req, 1);
      check("w3_addr", imem_addr, 0);
      check("w3_noack", imem_ack, 0);
      check("w3_nv", instr_valid, 0);
    end
    step(1, 0, 0);
    check("w3_ack", imem_ack, 1);
    step(1, 0, 0);
    check("w3_valid", instr_valid, 1);
    check("w3_pc", PC, 0);
    check("w3_next_addr", imem_addr, 32'd4);
    step(1, 0, 0);
    check("w3_popped", instr_valid, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    check("w3_pc4", PC, 32'd4);
    check("w3_addr8", imem_addr, 32'd8);
    step(1, 1, 32'h100);
    check("rd_wait_addr", imem_addr, 32'd8);
    check("rd_wait_noack", imem_ack, 0);
    step(1, 0, 0);
    check("drain_addr", imem_addr, 32'd8);
    check("drain_req", imem_req, 1);
    check("drain_nv", instr_valid, 0);
    step(1, 0, 0);
    check("drain_ack", imem_ack, 1);
    check("drain_ack_addr", imem_addr, 32'd8);
    step(1, 0, 0);
    check("drain_next_addr", imem_addr, 32'h100);
    check("drain_discard", instr_valid, 0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(1, 0, 0);
      found = instr_valid;
    end
    check("drain_timeout", 32'(found), 1);
    check("drain_first_pc", PC, 32'h100);
    check("drain_first_instr", instruction, 32'h1000_0100);
    do_reset(0);
    step(1, 0, 0);
    step(1, 1, 32'h40);
    check("rc_ack", imem_ack, 1);
    check("rc_pop", instr_valid, 1);
    step(1, 0, 0);
    check("rc_nv", instr_valid, 0);
    check("rc_req", imem_req, 1);
    check("rc_addr", imem_addr, 32'h40);
    step(1, 0, 0);
    check("rc_pc", PC, 32'h40);
    step(1, 1, 32'hFFFF_FFFC);
    step(1, 0, 0);
    check("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
    check("wrap_nv", instr_valid, 0);
    step(1, 0, 0);
    check("wrap_addr_zero", imem_addr, 0);
    check("wrap_pc", PC, 32'hFFFF_FFFC);
    step(1, 1, 32'h102);
`ifdef IFETCH_ALIGN_CHK_EN
    step(1, 0, 0);
    check("mis_fault", fetch_fault, 1);
    check("mis_req", imem_req, 0);
    check("mis_nv", instr_valid, 0);
    step(1, 0, 0);
    check("mis_fault_sticky", fetch_fault, 1);
    check("mis_req_hold", imem_req, 0);
    step(1, 1, 32'h200);
    step(1, 0, 0);
    check("mis_clear", fetch_fault, 0);
    check("mis_refetch_req", imem_req, 1);
    check("mis_refetch_addr", imem_addr, 32'h200);
    step(1, 0, 0);
    check("mis_refetch_pc", PC, 32'h200);
`else
    step(1, 0, 0);
    check("mis_nofault", fetch_fault, 0);
    check("mis_req", imem_req, 1);
    check("mis_addr", imem_addr, 32'h100);
    step(1, 0, 0);
    check("mis_pc", PC, 32'h100);
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
